// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data memory, one transaction at a time.
// Latency: request seen in IDLE -> bus_valid next cycle, done pulse one cycle after bus_rvalid; bus_ready low holds REQ.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_done,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  stallreq_axi
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state;
  logic   gnt;          // 0 = IF, 1 = MEM
  logic   if_served;
  logic   mem_served;
  logic   pend_if;
  logic   pend_mem;

  assign pend_if      = if_req & ~if_served;
  assign pend_mem     = mem_req & ~mem_served;
  assign stallreq_axi = rst_n & (pend_if | pend_mem);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      if_served  <= 1'b0;
      mem_served <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      // A stall-free cycle is the pipeline advancing: forget who was served.
      if (!stallreq_axi) begin
        if_served  <= 1'b0;
        mem_served <= 1'b0;
      end
      case (state)
        IDLE: begin
          // MEM first: it belongs to the older instruction.
          if (pend_mem) begin
            gnt       <= 1'b1;
            bus_valid <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_wstrb <= mem_wstrb;
            state     <= REQ;
          end else if (pend_if) begin
            gnt       <= 1'b0;
            bus_valid <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            if (!bus_we) begin
              if (gnt) mem_rdata <= bus_rdata;
              else     if_rdata  <= bus_rdata;
            end
            if_done  <= ~gnt;
            mem_done <= gnt;
            state    <= DONE;
          end
        end
        DONE: begin
          // Placed after the clear so a completion is never lost to it.
          if (gnt) mem_served <= 1'b1;
          else     if_served  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench for mem_port_arbiter, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          bus_valid;
  logic          bus_ready;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [7:0]    bus_wstrb;
  logic          bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic          stallreq_axi;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .stallreq_axi(stallreq_axi)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Model: served flags, the one outstanding transaction and the held read data.
  bit            m_srv_if, m_srv_mem;
  bit            m_act, m_acc, m_rsp, m_who;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ifr, m_memr;
  logic [7:0]    m_wstrb;

  function automatic bit exp_stall();
    return rst_n & ((if_req & ~m_srv_if) | (mem_req & ~m_srv_mem));
  endfunction

  task automatic model_step();
    bit pi, pm, stall, fin;
    if (!rst_n) begin
      m_srv_if = 0; m_srv_mem = 0; m_act = 0; m_acc = 0; m_rsp = 0; m_who = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_ifr = '0; m_memr = '0;
      return;
    end
    pi    = if_req & ~m_srv_if;
    pm    = mem_req & ~m_srv_mem;
    stall = pi | pm;
    fin   = 0;
    if (m_rsp) begin
      fin = 1; m_rsp = 0; m_act = 0;
    end else if (!m_act) begin
      if (pm) begin
        m_act = 1; m_acc = 0; m_who = 1;
        m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_wstrb = mem_wstrb;
      end else if (pi) begin
        m_act = 1; m_acc = 0; m_who = 0;
        m_we = 0; m_addr = if_addr; m_wdata = '0; m_wstrb = '0;
      end
    end else if (!m_acc) begin
      if (bus_ready) m_acc = 1;
    end else if (bus_rvalid) begin
      if (!m_we) begin
        if (m_who) m_memr = bus_rdata;
        else       m_ifr  = bus_rdata;
      end
      m_rsp = 1;
    end
    if (!stall) begin m_srv_if = 0; m_srv_mem = 0; end
    if (fin) begin
      if (m_who) m_srv_mem = 1;
      else       m_srv_if  = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  bit prev_stall;

  task automatic sample();
    @(negedge clk);
    chk("stallreq_axi", stallreq_axi, exp_stall());
    chk("bus_valid", bus_valid, m_act & ~m_acc);
    chk("bus_we",    bus_we,    m_we);
    chk("bus_addr",  bus_addr,  m_addr);
    chk("bus_wdata", bus_wdata, m_wdata);
    chk("bus_wstrb", bus_wstrb, m_wstrb);
    chk("if_done",   if_done,   m_rsp & ~m_who);
    chk("mem_done",  mem_done,  m_rsp & m_who);
    chk("if_rdata",  if_rdata,  m_ifr);
    chk("mem_rdata", mem_rdata, m_memr);
    prev_stall = exp_stall();
  endtask

  initial begin
    rst_n = 0; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    repeat (2) begin tick(); sample(); end
    chk("reset_stall", stallreq_axi, 1'b0);

    // Directed best-case IF read.
    tick(); rst_n = 1; if_req = 1; if_addr = 64'h8000_0000; sample();
    chk("c0_stall", stallreq_axi, 1'b1);
    chk("c0_valid", bus_valid, 1'b0);
    tick(); bus_ready = 1; sample();
    chk("c1_valid", bus_valid, 1'b1);
    chk("c1_addr", bus_addr, 64'h8000_0000);
    tick(); bus_ready = 0; bus_rvalid = 1; bus_rdata = 64'h1234; sample();
    chk("c2_stall", stallreq_axi, 1'b1);
    tick(); bus_rvalid = 0; sample();
    chk("c3_if_done", if_done, 1'b1);
    chk("c3_if_rdata", if_rdata, 64'h1234);
    chk("c3_stall", stallreq_axi, 1'b1);
    tick(); sample();
    chk("c4_stall", stallreq_axi, 1'b0);
    chk("c4_if_done", if_done, 1'b0);
    tick(); sample();
    chk("c5_flag_cleared", stallreq_axi, 1'b1);

    // Random phase: reqs held while stalled, renewed after a stall-free cycle.
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      if (!prev_stall) begin
        if_req  = $urandom_range(0, 1);
        mem_req = $urandom_range(0, 1);
      end else begin
        if ($urandom_range(0, 39) == 0) if_req  = 0;
        if ($urandom_range(0, 39) == 0) mem_req = 0;
      end
      if_addr   = {$urandom, $urandom};
      mem_we    = $urandom_range(0, 1);
      mem_addr  = {$urandom, $urandom};
      mem_wdata = {$urandom, $urandom};
      mem_wstrb = 8'($urandom);
      bus_ready = ($urandom_range(0, 2) != 0);
      bus_rdata = {$urandom, $urandom};
      if (m_act && m_acc && !m_rsp) bus_rvalid = ($urandom_range(0, 2) == 0);
      else if (!m_act)              bus_rvalid = ($urandom_range(0, 7) == 0);
      else                          bus_rvalid = 0;
      sample();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single external memory port between the instruction-fetch (IF) and data-memory (MEM) requesters. It sequences one transaction at a time over a valid/ready request channel with a separate response pulse. It raises `stallreq_axi` to the pipeline controller while any requester is unserved. Returned data is held stable in per-requester registers until the pipeline advances.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width (`DATA_W/8` byte strobes).

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  IF read request; held by the stalled pipeline until served.
- `if_addr`  in  ADDR_W  IF read address.
- `if_rdata`  out  DATA_W  registered IF read data.
- `if_done`  out  1  one-cycle pulse; `if_rdata` valid from this cycle on.
- `mem_req`  in  1  MEM request.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  ADDR_W  MEM address.
- `mem_wdata`  in  DATA_W  write data.
- `mem_wstrb`  in  DATA_W/8  byte strobes.
- `mem_rdata`  out  DATA_W  registered MEM read data.
- `mem_done`  out  1  one-cycle completion pulse.
- `bus_valid`  out  1  request valid.
- `bus_ready`  in  1  request accepted when `bus_valid & bus_ready`.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  request payload, registered.
- `bus_rvalid`  in  1  one-cycle response, reads and write acks; never in the same cycle as the accepting handshake.
- `bus_rdata`  in  DATA_W  response data, valid with `bus_rvalid`.
- `stallreq_axi`  out  1  pipeline stall request.

## Operation
- State flags `if_served` and `mem_served`, both registered.
- `pend_if = if_req & ~if_served`.
- `pend_mem = mem_req & ~mem_served`.
- `stallreq_axi = rst_n & (pend_if | pend_mem)`. Combinational from registered state.
- FSM states: IDLE, REQ, WAIT, DONE. A register `gnt` records the granted requester: 0 = IF, 1 = MEM.
- IDLE:
  - If `pend_mem`: `gnt<=1`, latch the MEM payload into `bus_*`, go to REQ.
  - Else if `pend_if`: `gnt<=0`, latch `if_addr` with `bus_we=0` and `bus_wstrb=0`, go to REQ.
  - MEM wins ties, because it carries the older instruction.
- REQ: `bus_valid=1` and the payload is held constant. On `bus_ready`, go to WAIT.
- WAIT: on `bus_rvalid`:
  - For a read, capture `bus_rdata` into `if_rdata` or `mem_rdata` according to `gnt`. For a write, leave both data registers untouched.
  - Go to DONE.
- DONE: pulse `if_done` or `mem_done` according to `gnt`, set that requester's served flag, return to IDLE.
- Served-flag clear: any cycle with `stallreq_axi==0` clears both served flags at the clock edge. That is the cycle in which the pipeline advances.
- A `*_req` that drops while its transaction is in flight does not abort it. The transaction completes, the done pulse fires, and the served flag is set.
- Input payload is sampled only at grant. Later changes are ignored.

## Timing
- Reset values:
  - state IDLE, `gnt` 0, served flags 0.
  - `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb` all 0.
  - `if_rdata`, `mem_rdata` 0.
  - `if_done`, `mem_done` 0.
  - `stallreq_axi` 0 while `rst_n==0`.
- Best-case latency, request first seen in IDLE at cycle 0:
  - `bus_valid` in cycle 1; `bus_ready=1` in cycle 1.
  - `bus_rvalid` in cycle 2.
  - done pulse in cycle 3.
  - `stallreq_axi` low in cycle 4 if nothing else is pending.
- `stallreq_axi` rises combinationally in the same cycle as the pending request. It stays high through DONE.
- With both requesters pending, MEM is served (DONE at cycle 3) and the IF grant follows. The IF transaction has `bus_valid` in cycle 5 and DONE in cycle 7, with `stallreq_axi` continuous until then.
- `bus_ready` low holds REQ indefinitely with a stable payload.
- A synchronous reset in any state returns to the reset values on the next edge. The in-flight bus transaction is abandoned, because the downstream port shares the reset.

## Test plan
- IF read at `if_addr=0x8000_0000`; `bus_ready=1` at cycle 1, `bus_rvalid` at cycle 2 with `bus_rdata=0x1234` -> `if_done` at cycle 3, `if_rdata=0x1234`, `stallreq_axi` 1 in cycles 0–3 and 0 in cycle 4, then the served flag clears.
- MEM write of `0xAABB` with `wstrb=0x03` at `0x100` -> bus shows `we=1`, `addr=0x100`, `wdata=0xAABB`, `wstrb=0x03`; `mem_done` after the ack; `mem_rdata` unchanged.
- `if_req` and `mem_req` rise together -> MEM granted first, IF second, each done pulse exactly once, stall continuous until IF DONE.
- `bus_ready` held low for 5 cycles in REQ -> `bus_valid` and payload constant for 6 cycles, WAIT only after acceptance.
- Served requester keeps `if_req` high while `mem_req` is still pending -> no second IF transaction; `if_rdata` stable until stall drops; both flags clear in the first stall-free cycle.
- `rst_n=0` for one cycle while in WAIT -> next cycle IDLE, all outputs at their reset values, no done pulse, a late `bus_rvalid` ignored.
